// File: rtl/ether_tx.sv
// ============================================================================
// Module   : ether_tx
// Brief    : RMII transmit framer: preamble/SFD insertion, payload dibit
//            forwarding and inter-frame gap enforcement.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ether_tx #(
  parameter int PREAMBLE_DIBITS = 28,
  parameter int IFG_DIBITS      = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  input  logic       axiil,
  output logic       axiir,
  output logic [1:0] txd,
  output logic       txen,
  output logic       done,
  output logic       underrun
);

  localparam logic [5:0] c_pre_last = 6'(PREAMBLE_DIBITS - 1);
  localparam logic [5:0] c_ifg_last = 6'(IFG_DIBITS - 1);
  localparam logic [5:0] c_sfd_last = 6'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_DATA = 3'd3,
    S_IFG  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] txd_q, txd_d;
  logic       txen_q, txen_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;

  // Each state names the pin values loaded at the coming edge; defaults idle the pins.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    txd_d      = 2'b00;
    txen_d     = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    axiir      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (axiiv) begin
          state_d = S_PRE;
          cnt_d   = 6'd0;
        end
      end
      S_PRE: begin
        txd_d  = 2'b01;
        txen_d = 1'b1;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == c_pre_last) begin
          state_d = S_SFD;
          cnt_d   = 6'd0;
        end
      end
      S_SFD: begin
        txen_d = 1'b1;
        txd_d  = (cnt_q == c_sfd_last) ? 2'b11 : 2'b01;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == c_sfd_last) begin
          state_d = S_DATA;
          cnt_d   = 6'd0;
        end
      end
      S_DATA: begin
        axiir = 1'b1;
        if (axiiv) begin
          txd_d  = axiid;
          txen_d = 1'b1;
          if (axiil) begin
            done_d  = 1'b1;
            state_d = S_IFG;
            cnt_d   = 6'd0;
          end
        end else begin
          // Source starved mid-frame: drop TX_EN immediately and fall into the gap.
          underrun_d = 1'b1;
          state_d    = S_IFG;
          cnt_d      = 6'd0;
        end
      end
      S_IFG: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == c_ifg_last) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      txd_q      <= 2'b00;
      txen_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      txd_q      <= txd_d;
      txen_q     <= txen_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign txd      = txd_q;
  assign txen     = txen_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

`default_nettype wire
